// File: rtl/register_file_pkg.sv
// Shared constants for the MIPS general-purpose register file.
package register_file_pkg;

    localparam int unsigned WORD_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned REG_COUNT      = 2 ** REG_ADDR_WIDTH;

    // Index of the hardwired-zero register ($0)
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

endpackage : register_file_pkg

// File: rtl/register_file_if.sv
// Read/write port bundle of the register file.
// The master drives the addresses and the write side; the slave returns the read data.
interface register_file_if
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] read_reg_1;
    logic [ADDR_WIDTH-1:0] read_reg_2;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  reg_write;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;

    modport master (
        output read_reg_1,
        output read_reg_2,
        output write_reg,
        output write_data,
        output reg_write,
        input  read_data_1,
        input  read_data_2
    );

    modport slave (
        input  read_reg_1,
        input  read_reg_2,
        input  write_reg,
        input  write_data,
        input  reg_write,
        output read_data_1,
        output read_data_2
    );

endinterface : register_file_if

// File: rtl/register_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports with
// write-through bypass, one synchronous write port, $0 hardwired to zero.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    register_file_if.slave   bus
);

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // Storage: synchronous clear, write to any register except $0
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (bus.reg_write && (bus.write_reg != '0)) begin
            regs[bus.write_reg] <= bus.write_data;
        end
    end

    // Read port 1: zero during reset or for $0, else bypass a same-cycle write, else stored value
    always_comb begin
        bus.read_data_1 = '0;
        if (!rst && (bus.read_reg_1 != '0)) begin
            if (bus.reg_write && (bus.write_reg == bus.read_reg_1)) begin
                bus.read_data_1 = bus.write_data;
            end else begin
                bus.read_data_1 = regs[bus.read_reg_1];
            end
        end
    end

    // Read port 2: identical to port 1
    always_comb begin
        bus.read_data_2 = '0;
        if (!rst && (bus.read_reg_2 != '0)) begin
            if (bus.reg_write && (bus.write_reg == bus.read_reg_2)) begin
                bus.read_data_2 = bus.write_data;
            end else begin
                bus.read_data_2 = regs[bus.read_reg_2];
            end
        end
    end

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    register_file #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .DEPTH      (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial forever #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Advance one clock; inputs change on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] rr1, input logic [4:0] rr2,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd);
        bus.read_reg_1 = rr1;
        bus.read_reg_2 = rr2;
        bus.reg_write  = we;
        bus.write_reg  = wr;
        bus.write_data = wd;
        #1;
    endtask

    initial begin
        bus.read_reg_1 = '0;
        bus.read_reg_2 = '0;
        bus.write_reg  = '0;
        bus.write_data = '0;
        bus.reg_write  = 1'b0;

        // Reset for two cycles; reads and bypass are suppressed while rst is high
        @(negedge clk);
        drive(5'd5, 5'd5, 1'b1, 5'd5, 32'h1234_5678);
        check_eq("rst_bypass_p1", bus.read_data_1, 32'h0);
        check_eq("rst_bypass_p2", bus.read_data_2, 32'h0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        tick();
        rst = 1'b0;

        // Every register reads zero after reset
        for (int i = 0; i < 32; i++) begin
            drive(5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0);
            check_eq($sformatf("post_rst_p1_r%0d", i), bus.read_data_1, 32'h0);
            check_eq($sformatf("post_rst_p2_r%0d", 31 - i), bus.read_data_2, 32'h0);
        end

        // Plain write then read next cycle
        drive(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        drive(5'd5, 5'd6, 1'b0, 5'd0, 32'h0);
        check_eq("wr5_rd_p1", bus.read_data_1, 32'hDEAD_BEEF);
        check_eq("wr5_other_p2", bus.read_data_2, 32'h0);

        // Write to $0 is dropped, including on the bypass path
        drive(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        check_eq("wr0_bypass_p1", bus.read_data_1, 32'h0);
        check_eq("wr0_bypass_p2", bus.read_data_2, 32'h0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        check_eq("wr0_rd_p1", bus.read_data_1, 32'h0);
        check_eq("wr0_rd_p2", bus.read_data_2, 32'h0);

        // Bypass on both ports for the same register, value persists
        drive(5'd0, 5'd0, 1'b1, 5'd7, 32'h1111_1111);
        tick();
        drive(5'd7, 5'd7, 1'b0, 5'd0, 32'h0);
        check_eq("r7_old_p1", bus.read_data_1, 32'h1111_1111);
        drive(5'd7, 5'd7, 1'b1, 5'd7, 32'h2222_2222);
        check_eq("r7_bypass_p1", bus.read_data_1, 32'h2222_2222);
        check_eq("r7_bypass_p2", bus.read_data_2, 32'h2222_2222);
        tick();
        drive(5'd7, 5'd7, 1'b0, 5'd0, 32'h0);
        check_eq("r7_after_p1", bus.read_data_1, 32'h2222_2222);
        check_eq("r7_after_p2", bus.read_data_2, 32'h2222_2222);

        // Bypass only affects the port whose address matches
        drive(5'd5, 5'd7, 1'b1, 5'd5, 32'h0BAD_F00D);
        check_eq("partial_bypass_p1", bus.read_data_1, 32'h0BAD_F00D);
        check_eq("partial_bypass_p2", bus.read_data_2, 32'h2222_2222);
        tick();

        // Reset in the same cycle as a write discards the write and clears everything
        rst = 1'b1;
        drive(5'd31, 5'd7, 1'b1, 5'd31, 32'hA5A5_A5A5);
        check_eq("rst_wr_p1", bus.read_data_1, 32'h0);
        check_eq("rst_wr_p2", bus.read_data_2, 32'h0);
        tick();
        rst = 1'b0;
        drive(5'd31, 5'd7, 1'b0, 5'd0, 32'h0);
        check_eq("rst_wr_r31", bus.read_data_1, 32'h0);
        check_eq("rst_clr_r7", bus.read_data_2, 32'h0);
        drive(5'd5, 5'd0, 1'b0, 5'd0, 32'h0);
        check_eq("rst_clr_r5", bus.read_data_1, 32'h0);

        // Fill 1..31 with index * 0x01010101, then walk both ports
        for (int i = 1; i < 32; i++) begin
            drive(5'd0, 5'd0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101);
            tick();
        end
        for (int i = 1; i < 32; i++) begin
            drive(5'(i), 5'(32 - i), 1'b0, 5'd0, 32'h0);
            check_eq($sformatf("fill_p1_r%0d", i), bus.read_data_1, 32'(i) * 32'h0101_0101);
            check_eq($sformatf("fill_p2_r%0d", 32 - i), bus.read_data_2, 32'(32 - i) * 32'h0101_0101);
        end
        drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        check_eq("fill_r0_p1", bus.read_data_1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register_file
